store_cntrl: RTL and testbench

STORE_CNTRL -- requirements
Module: store_cntrl

---
 rtl/core_pkg.sv | 39 +++
 rtl/store_cntrl_if.sv | 27 ++
 rtl/store_fmt.sv | 41 ++++
 rtl/store_cntrl.sv | 112 +++++++++++
 tb/tb_store_cntrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared memory-op encodings and store-buffer data types for the core.
// Store ops carry STORE_PRFX in bit 0; the size helper maps an op to its byte count.
package core;

   typedef enum logic [3:0] {
      MEM_NOP = 4'b0000,
      LB      = 4'b0010,
      LH      = 4'b0100,
      LW      = 4'b0110,
      LBU     = 4'b1000,
      LHU     = 4'b1010,
      SB      = 4'b0001,
      SH      = 4'b0011,
      SW      = 4'b0101
   } mem_op_t;

   localparam logic STORE_PRFX = 1'b1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } store_beat_t;

   typedef struct packed {
      store_beat_t beat0;
      store_beat_t beat1;
      logic        has_beat1;
   } store_entry_t;

   function automatic logic [2:0] op_size(mem_op_t op);
      case (op)
         SB:      return 3'd1;
         SH:      return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/store_cntrl_if.sv
// Pipeline-side store port and data-memory write port of the store buffer.
interface store_cntrl_if;

   logic          st_valid_i;
   core::mem_op_t st_op_i;
   logic [31:0]   st_addr_i;
   logic [31:0]   st_data_i;
   logic          st_ready_o;
   logic          mem_req_o;
   logic          mem_gnt_i;
   logic          mem_we_o;
   logic [31:0]   mem_addr_o;
   logic [31:0]   mem_wdata_o;
   logic [3:0]    mem_be_o;
   logic          sb_empty_o;

   modport slave (
      input  st_valid_i, st_op_i, st_addr_i, st_data_i, mem_gnt_i,
      output st_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, sb_empty_o
   );

   modport master (
      output st_valid_i, st_op_i, st_addr_i, st_data_i, mem_gnt_i,
      input  st_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, sb_empty_o
   );

endinterface

// File: rtl/store_fmt.sv
// Splits a byte-addressed store into one or two word-aligned beats with lane enables.
module store_fmt
   import core::*;
(
   input  mem_op_t      op,
   input  logic [31:0]  addr,
   input  logic [31:0]  data,
   output store_entry_t entry
);

   logic [1:0]  off;
   logic [2:0]  size;
   logic [31:0] word;
   logic [63:0] lane_data;
   logic [7:0]  lane_mask;

   assign off       = addr[1:0];
   assign size      = op_size(op);
   assign word      = {addr[31:2], 2'b00};
   assign lane_data = {32'd0, data} << {off, 3'b000};

   // Lanes 4..7 of the two-word window spill into the following word.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign lane_mask[gi] = (4'(gi) >= {2'b00, off}) &&
                                (4'(gi) < ({2'b00, off} + {1'b0, size}));
      end
   endgenerate

   always_comb begin
      entry.beat0.addr  = word;
      entry.beat0.wdata = lane_data[31:0];
      entry.beat0.be    = lane_mask[3:0];
      entry.beat1.addr  = word + 32'd4;
      entry.beat1.wdata = lane_data[63:32];
      entry.beat1.be    = lane_mask[7:4];
      entry.has_beat1   = |lane_mask[7:4];
   end

endmodule

// File: rtl/store_cntrl.sv
// Store buffer: FIFO of formatted stores drained to data memory one beat per grant.
// Request fields come from a beat register loaded on the edge that enters each beat.
module store_cntrl
   import core::*;
#(
   parameter int DEPTH = 2
) (
   input logic          clk_i,
   input logic          rst_i,
   store_cntrl_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} drain_state_t;

   drain_state_t  state_reg, state_next;
   store_entry_t  fifo_mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg, count_next;
   store_beat_t   beat_reg, beat_next;
   store_entry_t  fmt_entry, head_entry, next_entry;
   logic          full, enq, pop, more;

   store_fmt u_fmt (
      .op    (bus.st_op_i),
      .addr  (bus.st_addr_i),
      .data  (bus.st_data_i),
      .entry (fmt_entry)
   );

   assign full = (count_reg == CW'(DEPTH));
   assign enq  = bus.st_valid_i && !full &&
                 (bus.st_op_i[0] == STORE_PRFX) && (bus.st_op_i != MEM_NOP);

   // After popping the head, the next entry is either already queued or arriving now.
   assign head_entry = fifo_mem[rd_ptr_reg];
   assign next_entry = (count_reg > CW'(1)) ? fifo_mem[rd_ptr_reg + PW'(1)] : fmt_entry;
   assign more       = (count_reg > CW'(1)) || enq;

   always_comb begin
      state_next = state_reg;
      beat_next  = beat_reg;
      pop        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0) begin
               state_next = BEAT0;
               beat_next  = head_entry.beat0;
            end else if (enq) begin
               state_next = BEAT0;
               beat_next  = fmt_entry.beat0;
            end
         end
         BEAT0: begin
            if (bus.mem_gnt_i) begin
               if (head_entry.has_beat1) begin
                  state_next = BEAT1;
                  beat_next  = head_entry.beat1;
               end else begin
                  pop        = 1'b1;
                  state_next = more ? BEAT0 : IDLE;
                  beat_next  = more ? next_entry.beat0 : '0;
               end
            end
         end
         BEAT1: begin
            if (bus.mem_gnt_i) begin
               pop        = 1'b1;
               state_next = more ? BEAT0 : IDLE;
               beat_next  = more ? next_entry.beat0 : '0;
            end
         end
         default: begin
            state_next = IDLE;
            beat_next  = '0;
         end
      endcase
   end

   assign count_next = count_reg + CW'(enq) - CW'(pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg  <= IDLE;
         beat_reg   <= '0;
         count_reg  <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         state_reg <= state_next;
         beat_reg  <= beat_next;
         count_reg <= count_next;
         if (enq) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) fifo_mem[wr_ptr_reg] <= fmt_entry;
   end

   assign bus.st_ready_o  = !full;
   assign bus.mem_req_o   = (state_reg != IDLE);
   assign bus.mem_we_o    = (state_reg != IDLE);
   assign bus.mem_addr_o  = beat_reg.addr;
   assign bus.mem_wdata_o = beat_reg.wdata;
   assign bus.mem_be_o    = beat_reg.be;
   assign bus.sb_empty_o  = (count_reg == '0) && (state_reg == IDLE);

endmodule

// File: tb/tb_store_cntrl.sv
// Bench for store_cntrl: directed vector table, back-pressure and reset sequences,
// then random traffic checked against a queue-of-beats reference model.
module tb_store_cntrl;
   import core::*;

   localparam int DEPTH = 2;
   localparam int NV    = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   store_cntrl_if bus ();

   store_cntrl #(.DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      bit          last;
   } exp_beat_t;

   typedef struct {
      mem_op_t     op;
      logic [31:0] addr;
      logic [31:0] data;
      int          nb;
      logic [31:0] a0;
      logic [3:0]  be0;
      logic [31:0] w0;
      logic [31:0] a1;
      logic [3:0]  be1;
      logic [31:0] w1;
   } vec_t;

   exp_beat_t beat_q[$];
   int        occ    = 0;
   int        checks = 0;
   int        errors = 0;
   vec_t      vecs[NV];
   mem_op_t   ops[9] = '{MEM_NOP, LB, LH, LW, LBU, LHU, SB, SH, SW};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic bit is_store(input mem_op_t op);
      return (op == SB) || (op == SH) || (op == SW);
   endfunction

   // Reference: walk the bytes of the store and drop each into its lane of word or word+4.
   task automatic model_push(input mem_op_t op, input logic [31:0] a, input logic [31:0] d);
      int size = (op == SB) ? 1 : (op == SH) ? 2 : 4;
      int off  = int'(a[1:0]);
      exp_beat_t b0, b1;
      b0.addr = a & 32'hFFFF_FFFC;
      b1.addr = b0.addr + 32'd4;
      b0.be   = 4'b0000;
      b1.be   = 4'b0000;
      for (int k = 0; k < size; k++) begin
         if (off + k < 4) b0.be[off + k] = 1'b1;
         else             b1.be[off + k - 4] = 1'b1;
      end
      b0.wdata = d << (8 * off);
      b1.wdata = d >> (8 * (4 - off));
      b0.last  = (b1.be == 4'b0000);
      b1.last  = 1'b1;
      beat_q.push_back(b0);
      if (b1.be != 4'b0000) beat_q.push_back(b1);
      occ++;
   endtask

   task automatic check_outputs();
      bit exp_req;
      exp_req = (beat_q.size() > 0);
      check("st_ready", 32'(bus.st_ready_o), 32'(occ < DEPTH));
      check("mem_req",  32'(bus.mem_req_o),  32'(exp_req));
      check("mem_we",   32'(bus.mem_we_o),   32'(exp_req));
      check("sb_empty", 32'(bus.sb_empty_o), 32'(occ == 0));
      if (exp_req) begin
         check("mem_addr",  bus.mem_addr_o,       beat_q[0].addr);
         check("mem_be",    32'(bus.mem_be_o),    32'(beat_q[0].be));
         check("mem_wdata", bus.mem_wdata_o,      beat_q[0].wdata);
      end
   endtask

   // Called at a negedge: drive one cycle of inputs, advance the model over the edge, check.
   task automatic step(input logic v, input mem_op_t op, input logic [31:0] a,
                       input logic [31:0] d, input logic g, output bit acc);
      exp_beat_t b;
      acc = v && is_store(op) && (occ < DEPTH);
      bus.st_valid_i = v;
      bus.st_op_i    = op;
      bus.st_addr_i  = a;
      bus.st_data_i  = d;
      bus.mem_gnt_i  = g;
      @(posedge clk);
      if (g && beat_q.size() > 0) begin
         b = beat_q.pop_front();
         $display("beat granted: addr=0x%08h be=%b wdata=0x%08h", b.addr, b.be, b.wdata);
         if (b.last) occ--;
      end
      if (acc) model_push(op, a, d);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.st_valid_i = 1'b0;
      bus.st_op_i    = MEM_NOP;
      bus.mem_gnt_i  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      beat_q.delete();
      occ = 0;
      check("rst mem_req",   32'(bus.mem_req_o),  32'd0);
      check("rst mem_we",    32'(bus.mem_we_o),   32'd0);
      check("rst mem_addr",  bus.mem_addr_o,      32'd0);
      check("rst mem_wdata", bus.mem_wdata_o,     32'd0);
      check("rst mem_be",    32'(bus.mem_be_o),   32'd0);
      check("rst st_ready",  32'(bus.st_ready_o), 32'd1);
      check("rst sb_empty",  32'(bus.sb_empty_o), 32'd1);
      $display("reset applied");
   endtask

   initial begin
      bit acc;
      bit pending_c;
      bit v, g;
      logic [31:0] a;

      bus.st_valid_i = 1'b0;
      bus.st_op_i    = MEM_NOP;
      bus.st_addr_i  = '0;
      bus.st_data_i  = '0;
      bus.mem_gnt_i  = 1'b0;

      vecs[0] = '{SB, 32'h0000_1002, 32'hAABB_CCDD, 1, 32'h0000_1000, 4'b0100, 32'hCCDD_0000, 32'd0, 4'b0000, 32'd0};
      vecs[1] = '{SW, 32'h0000_2003, 32'h1122_3344, 2, 32'h0000_2000, 4'b1000, 32'h4400_0000, 32'h0000_2004, 4'b0111, 32'h0011_2233};
      vecs[2] = '{SW, 32'hFFFF_FFFE, 32'hCAFE_BABE, 2, 32'hFFFF_FFFC, 4'b1100, 32'hBABE_0000, 32'h0000_0000, 4'b0011, 32'h0000_CAFE};
      vecs[3] = '{SH, 32'h0000_3FFF, 32'h0000_BEEF, 2, 32'h0000_3FFC, 4'b1000, 32'hEF00_0000, 32'h0000_4000, 4'b0001, 32'h0000_00BE};
      vecs[4] = '{SW, 32'h0000_0100, 32'h1234_5678, 1, 32'h0000_0100, 4'b1111, 32'h1234_5678, 32'd0, 4'b0000, 32'd0};
      vecs[5] = '{SH, 32'h0000_0021, 32'h0000_1234, 1, 32'h0000_0020, 4'b0110, 32'h0012_3400, 32'd0, 4'b0000, 32'd0};
      vecs[6] = '{SW, 32'h0000_0041, 32'hAABB_CCDD, 2, 32'h0000_0040, 4'b1110, 32'hBBCC_DD00, 32'h0000_0044, 4'b0001, 32'h0000_00AA};
      vecs[7] = '{LW, 32'h0000_0080, 32'hDEAD_BEEF, 0, 32'd0, 4'b0000, 32'd0, 32'd0, 4'b0000, 32'd0};

      do_reset();

      // Directed vectors, each isolated with gnt tied high.
      for (int i = 0; i < NV; i++) begin
         step(1'b1, vecs[i].op, vecs[i].addr, vecs[i].data, 1'b1, acc);
         if (vecs[i].nb == 0) begin
            check("tbl load empty", 32'(bus.sb_empty_o), 32'd1);
            check("tbl load req",   32'(bus.mem_req_o),  32'd0);
         end else begin
            check("tbl beat0 req",   32'(bus.mem_req_o), 32'd1);
            check("tbl beat0 addr",  bus.mem_addr_o,     vecs[i].a0);
            check("tbl beat0 be",    32'(bus.mem_be_o),  32'(vecs[i].be0));
            check("tbl beat0 wdata", bus.mem_wdata_o,    vecs[i].w0);
         end
         step(1'b0, MEM_NOP, 32'd0, 32'd0, 1'b1, acc);
         if (vecs[i].nb == 2) begin
            check("tbl beat1 req",   32'(bus.mem_req_o), 32'd1);
            check("tbl beat1 addr",  bus.mem_addr_o,     vecs[i].a1);
            check("tbl beat1 be",    32'(bus.mem_be_o),  32'(vecs[i].be1));
            check("tbl beat1 wdata", bus.mem_wdata_o,    vecs[i].w1);
         end
         step(1'b0, MEM_NOP, 32'd0, 32'd0, 1'b1, acc);
         check("tbl drained", 32'(bus.sb_empty_o), 32'd1);
      end

      // Back-pressure: gnt low for five cycles while three stores are offered.
      step(1'b1, SW, 32'h0000_5000, 32'h0101_0101, 1'b0, acc);
      step(1'b1, SH, 32'h0000_5106, 32'h0000_0202, 1'b0, acc);
      check("bp ready low", 32'(bus.st_ready_o), 32'd0);
      for (int c = 0; c < 3; c++) begin
         step(1'b1, SB, 32'h0000_5203, 32'h0000_0033, 1'b0, acc);
         check("bp addr hold", bus.mem_addr_o,    32'h0000_5000);
         check("bp be hold",   32'(bus.mem_be_o), 32'hF);
      end
      pending_c = 1'b1;
      for (int c = 0; c < 20 && (pending_c || beat_q.size() > 0); c++) begin
         step(pending_c, SB, 32'h0000_5203, 32'h0000_0033, 1'b1, acc);
         if (acc) pending_c = 1'b0;
      end
      check("bp third accepted", 32'(pending_c), 32'd0);
      check("bp drained", 32'(bus.sb_empty_o), 32'd1);

      // Reset while the second beat of a word-crossing SH is on the bus.
      step(1'b1, SH, 32'h0000_3FFF, 32'h0000_BEEF, 1'b1, acc);
      step(1'b0, MEM_NOP, 32'd0, 32'd0, 1'b1, acc);
      check("mid-rst in beat1", bus.mem_addr_o, 32'h0000_4000);
      do_reset();
      for (int c = 0; c < 3; c++) begin
         step(1'b0, MEM_NOP, 32'd0, 32'd0, 1'b1, acc);
         check("post-rst no req", 32'(bus.mem_req_o), 32'd0);
      end

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         v = ($urandom_range(0, 3) != 0);
         g = ($urandom_range(0, 3) != 0);
         a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
         step(v, ops[$urandom_range(0, 8)], a, $urandom, g, acc);
      end
      for (int c = 0; c < 20 && beat_q.size() > 0; c++) begin
         step(1'b0, MEM_NOP, 32'd0, 32'd0, 1'b1, acc);
      end
      check("random drained", 32'(bus.sb_empty_o), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
